// File: rtl/booth_issue_ctrl_if.sv
// Operand/result handshake bus plus the start/busy/z link to the sequential Booth multiplier.
// The master side is the issue controller; the slave side is its environment.
interface booth_issue_ctrl_if #(
    parameter int WIDTH = 16
);
    // operand port
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   in_x;
    logic signed [WIDTH-1:0]   in_y;

    // result port
    logic                      out_valid;
    logic                      out_ready;
    logic signed [2*WIDTH-1:0] out_z;

    // multiplier link
    logic signed [WIDTH-1:0]   mul_x;
    logic signed [WIDTH-1:0]   mul_y;
    logic                      mul_start;
    logic                      mul_busy;
    logic signed [2*WIDTH-1:0] mul_z;

    modport master (
        input  in_valid, in_x, in_y, out_ready, mul_busy, mul_z,
        output in_ready, out_valid, out_z, mul_x, mul_y, mul_start
    );

    modport slave (
        output in_valid, in_x, in_y, out_ready, mul_busy, mul_z,
        input  in_ready, out_valid, out_z, mul_x, mul_y, mul_start
    );
endinterface

// File: rtl/booth_issue_ctrl.sv
// Issue controller for a sequential Booth multiplier: operand FIFO, one-at-a-time launch,
// registered result slot whose drain overlaps the next launch.
module booth_issue_ctrl #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    booth_issue_ctrl_if.master      bus,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    err
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic signed [WIDTH-1:0]   fifo_x [DEPTH];
    logic signed [WIDTH-1:0]   fifo_y [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [AW:0]               count;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;

    state_t                    state_q;
    state_t                    state_d;
    logic [TW-1:0]             tcnt;
    logic                      capture;
    logic                      timeout_hit;
    logic                      slot_free;

    logic signed [WIDTH-1:0]   mul_x_p0;
    logic signed [WIDTH-1:0]   mul_y_p0;
    logic                      vld_p1;
    logic signed [2*WIDTH-1:0] out_z_p1;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign push      = bus.in_valid && !full;
    assign slot_free = !vld_p1 || bus.out_ready;

    // ---- operand FIFO ----
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x[wr_ptr] <= bus.in_x;
            fifo_y[wr_ptr] <= bus.in_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---- issue FSM ----
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.mul_busy) begin
                    state_d = WAIT_DONE;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT_DONE: begin
                // The multiplier holds z until the next start, so waiting for the slot is safe.
                if (!bus.mul_busy && slot_free) begin
                    capture = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = LAUNCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tcnt    <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt    <= (state_q == WAIT_BUSY) ? tcnt + 1'b1 : '0;
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

    // ---- operand launch registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_x_p0 <= '0;
            mul_y_p0 <= '0;
        end else if (pop) begin
            mul_x_p0 <= fifo_x[rd_ptr];
            mul_y_p0 <= fifo_y[rd_ptr];
        end
    end

    // ---- result slot ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            out_z_p1 <= '0;
        end else begin
            if (capture) begin
                vld_p1   <= 1'b1;
                out_z_p1 <= bus.mul_z;
            end else if (bus.out_ready) begin
                vld_p1   <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = !full;
    assign bus.mul_x     = mul_x_p0;
    assign bus.mul_y     = mul_y_p0;
    assign bus.mul_start = (state_q == LAUNCH);
    assign bus.out_valid = vld_p1;
    assign bus.out_z     = out_z_p1;
    assign level         = count;
endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Bench for booth_issue_ctrl: a behavioural sequential multiplier plus scenario tasks and a
// randomized run scored against a queue of expected products.
`timescale 1ns/1ps
module tb_booth_issue_ctrl;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 4;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] level;
    logic          err;
    int            tests = 0;
    int            fails = 0;

    booth_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    booth_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .level (level),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p[2*WIDTH-1:0];
    endfunction

    // Multiplier: busy for WIDTH cycles after a start, garbage on z until done, z held afterwards.
    logic                 mul_dead = 1'b0;
    int                   mcnt;
    logic [WIDTH-1:0]     mop_x;
    logic [WIDTH-1:0]     mop_y;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mul_busy <= 1'b0;
            bus.mul_z    <= '0;
            mcnt         <= 0;
        end else if (bus.mul_start && !bus.mul_busy && !mul_dead) begin
            bus.mul_busy <= 1'b1;
            bus.mul_z    <= $urandom;
            mcnt         <= WIDTH;
            mop_x        <= bus.mul_x;
            mop_y        <= bus.mul_y;
        end else if (bus.mul_busy) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                bus.mul_busy <= 1'b0;
                bus.mul_z    <= ref_mul(mop_x, mop_y);
            end
        end
    end

    // Values observed just before the edge that the last step drove toward.
    logic               s_pushed, s_popped, s_ov, s_ms, s_err;
    logic [2*WIDTH-1:0] s_z;
    logic [WIDTH-1:0]   s_mx, s_my;

    task automatic step(input logic iv, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.out_ready = ordy;
        #1;
        s_pushed = iv && bus.in_ready;
        s_popped = bus.out_valid && ordy;
        s_ov     = bus.out_valid;
        s_z      = bus.out_z;
        s_ms     = bus.mul_start;
        s_mx     = bus.mul_x;
        s_my     = bus.mul_y;
        s_err    = err;
        @(posedge clk);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        tests++; if (bus.out_z !== '0) begin fails++; $display("FAIL reset_out_z got %h want 0", bus.out_z); end
        tests++; if ({bus.mul_x, bus.mul_y} !== '0) begin fails++; $display("FAIL reset_mul_xy got %h/%h want 0", bus.mul_x, bus.mul_y); end
        tests++; if (bus.mul_start !== 1'b0) begin fails++; $display("FAIL reset_mul_start got %b want 0", bus.mul_start); end
        tests++; if (level !== '0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, '0, '0, 1'b1);
        tests++; if (s_ov !== 1'b0 || s_ms !== 1'b0) begin fails++; $display("FAIL idle_quiet got ov=%b start=%b want 0/0", s_ov, s_ms); end
    endtask

    task automatic test_latency();
        int rise = -1;
        int vcount = 0;
        logic [2*WIDTH-1:0] zcap = '0;
        step(1'b1, 16'd3, 16'hFFFB, 1'b1);
        tests++; if (s_pushed !== 1'b1) begin fails++; $display("FAIL lat_push got %b want 1", s_pushed); end
        for (int s = 1; s <= 35; s++) begin
            step(1'b0, '0, '0, 1'b1);
            if (s_ov === 1'b1) begin
                if (rise < 0) begin rise = s - 1; zcap = s_z; end
                vcount++;
            end
        end
        tests++; if (rise != WIDTH + 3) begin fails++; $display("FAIL lat_edge got %0d want %0d", rise, WIDTH + 3); end
        tests++; if (zcap !== 32'hFFFFFFF1) begin fails++; $display("FAIL lat_value got %h want fffffff1", zcap); end
        tests++; if (vcount != 1) begin fails++; $display("FAIL lat_one_cycle got %0d cycles want 1", vcount); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0]   xs [4] = '{16'd7, 16'hFFFF, 16'd0, 16'd100};
        logic [WIDTH-1:0]   ys [4] = '{16'd6, 16'hFFFF, 16'd1234, 16'hFF9C};
        logic [2*WIDTH-1:0] ex [4] = '{32'd42, 32'd1, 32'd0, 32'hFFFFD8F0};
        int t_prev = -1;
        int got = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, xs[i], ys[i], 1'b1);
            tests++; if (s_pushed !== 1'b1) begin fails++; $display("FAIL b2b_push%0d got %b want 1", i, s_pushed); end
        end
        for (int s = 4; s < 200 && got < 4; s++) begin
            step(1'b0, '0, '0, 1'b1);
            if (s_popped) begin
                tests++; if (s_z !== ex[got]) begin fails++; $display("FAIL b2b_z%0d got %h want %h", got, s_z, ex[got]); end
                if (got == 0) begin
                    tests++; if (s - 1 != WIDTH + 3) begin fails++; $display("FAIL b2b_first_edge got %0d want %0d", s - 1, WIDTH + 3); end
                end else begin
                    tests++; if (s - t_prev > WIDTH + 3) begin fails++; $display("FAIL b2b_gap%0d got %0d want <= %0d", got, s - t_prev, WIDTH + 3); end
                end
                t_prev = s;
                got++;
            end
        end
        tests++; if (got != 4) begin fails++; $display("FAIL b2b_count got %0d want 4", got); end
    endtask

    task automatic test_extremes();
        logic [2*WIDTH-1:0] ex [2] = '{32'h40000000, 32'hC0008000};
        int got = 0;
        step(1'b1, 16'h8000, 16'h8000, 1'b1);
        step(1'b1, 16'h8000, 16'h7FFF, 1'b1);
        for (int s = 0; s < 100 && got < 2; s++) begin
            step(1'b0, '0, '0, 1'b1);
            if (s_popped) begin
                tests++; if (s_z !== ex[got]) begin fails++; $display("FAIL ext_z%0d got %h want %h", got, s_z, ex[got]); end
                got++;
            end
        end
        tests++; if (got != 2) begin fails++; $display("FAIL ext_count got %0d want 2", got); end
    endtask

    task automatic test_backpressure();
        logic [2*WIDTH-1:0] exq [$];
        logic [2*WIDTH-1:0] held;
        logic [WIDTH-1:0]   x, y;
        int seen = 0;
        int got = 0;
        for (int i = 0; i < 5; i++) begin
            x = 16'($urandom); y = 16'($urandom);
            step(1'b1, x, y, 1'b0);
            tests++; if (s_pushed !== 1'b1) begin fails++; $display("FAIL bp_push%0d got %b want 1", i, s_pushed); end
            if (s_pushed) exq.push_back(ref_mul(x, y));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'd11, 16'd13, 1'b0);
            tests++; if (s_pushed !== 1'b0) begin fails++; $display("FAIL bp_sixth_try%0d got %b want 0", i, s_pushed); end
        end
        @(negedge clk); #1;
        tests++; if (level !== LW'(DEPTH)) begin fails++; $display("FAIL bp_level got %0d want %0d", level, DEPTH); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
        for (int s = 0; s < 40 && !seen; s++) begin
            step(1'b0, '0, '0, 1'b0);
            if (s_ov) seen = 1;
        end
        tests++; if (!seen) begin fails++; $display("FAIL bp_first_valid got none want out_valid within 40 cycles"); end
        held = s_z;
        tests++; if (held !== exq[0]) begin fails++; $display("FAIL bp_held_value got %h want %h", held, exq[0]); end
        for (int s = 0; s < 30; s++) begin
            step(1'b0, '0, '0, 1'b0);
            if (s_ov !== 1'b1 || s_z !== held) begin
                tests++; fails++; $display("FAIL bp_stable got ov=%b z=%h want 1/%h", s_ov, s_z, held);
                break;
            end
        end
        for (int s = 0; s < 200 && got < 5; s++) begin
            step(1'b0, '0, '0, 1'b1);
            if (s_popped) begin
                tests++; if (s_z !== exq[got]) begin fails++; $display("FAIL bp_order%0d got %h want %h", got, s_z, exq[got]); end
                got++;
            end
        end
        tests++; if (got != 5) begin fails++; $display("FAIL bp_drain_count got %0d want 5", got); end
    endtask

    task automatic test_timeout();
        int found = 0;
        int bad = 0;
        int got = 0;
        mul_dead = 1'b1;
        step(1'b1, 16'd5, 16'd5, 1'b1);
        for (int s = 0; s < 10 && !found; s++) begin
            step(1'b0, '0, '0, 1'b1);
            if (s_ms) found = 1;
        end
        tests++; if (!found) begin fails++; $display("FAIL to_launch got no mul_start want one within 10 cycles"); end
        for (int n = 1; n <= TIMEOUT + 1; n++) begin
            step(1'b0, '0, '0, 1'b1);
            if (n == TIMEOUT) begin
                tests++; if (s_err !== 1'b0) begin fails++; $display("FAIL to_err_early got %b want 0", s_err); end
            end
            if (n == TIMEOUT + 1) begin
                tests++; if (s_err !== 1'b1) begin fails++; $display("FAIL to_err_set got %b want 1", s_err); end
            end
        end
        for (int s = 0; s < 20; s++) begin
            step(1'b0, '0, '0, 1'b1);
            if (s_ov || s_ms) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL to_dropped got %0d active cycles want 0", bad); end
        mul_dead = 1'b0;
        step(1'b1, 16'd9, 16'd9, 1'b1);
        for (int s = 0; s < 40 && got == 0; s++) begin
            step(1'b0, '0, '0, 1'b1);
            if (s_popped) begin
                got = 1;
                tests++; if (s_z !== 32'd81) begin fails++; $display("FAIL to_recover_z got %h want 00000051", s_z); end
                tests++; if (s_err !== 1'b1) begin fails++; $display("FAIL to_err_sticky got %b want 1", s_err); end
            end
        end
        tests++; if (got != 1) begin fails++; $display("FAIL to_recover_count got %0d want 1", got); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int got = 0;
        step(1'b1, 16'd21, 16'd2, 1'b0);
        step(1'b1, 16'd17, 16'd3, 1'b0);
        for (int s = 0; s < 40 && !seen; s++) begin
            step(1'b0, '0, '0, 1'b0);
            if (s_ov) seen = 1;
        end
        tests++; if (!seen) begin fails++; $display("FAIL rm_setup got no out_valid want one within 40 cycles"); end
        repeat (8) step(1'b0, '0, '0, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rm_out_valid got %b want 0", bus.out_valid); end
        tests++; if (bus.out_z !== '0) begin fails++; $display("FAIL rm_out_z got %h want 0", bus.out_z); end
        tests++; if ({bus.mul_x, bus.mul_y} !== '0) begin fails++; $display("FAIL rm_mul_xy got %h/%h want 0", bus.mul_x, bus.mul_y); end
        tests++; if (bus.mul_start !== 1'b0) begin fails++; $display("FAIL rm_mul_start got %b want 0", bus.mul_start); end
        tests++; if (level !== '0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL rm_fifo got level=%0d in_ready=%b want 0/1", level, bus.in_ready); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rm_err got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h1234, 16'hFEDC, 1'b1);
        for (int s = 0; s < 40 && got == 0; s++) begin
            step(1'b0, '0, '0, 1'b1);
            if (s_popped) begin
                got = 1;
                tests++; if (s_z !== 32'hFFEB3CB0) begin fails++; $display("FAIL rm_next_z got %h want ffeb3cb0", s_z); end
            end
        end
        tests++; if (got != 1) begin fails++; $display("FAIL rm_next_count got %0d want 1", got); end
    endtask

    task automatic test_random();
        logic [2*WIDTH-1:0] exq [$];
        logic [2*WIDTH-1:0] opq [$];
        logic [WIDTH-1:0]   corner [4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
        logic [WIDTH-1:0]   x, y;
        logic               iv, ordy, prev_hold;
        logic [2*WIDTH-1:0] prev_z;
        int sent = 0;
        int recv = 0;
        int s = 0;
        prev_hold = 1'b0;
        prev_z = '0;
        while (recv < 40 && s < 4000) begin
            iv = (sent < 40) && ($urandom_range(0, 9) < 7);
            x = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            y = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            ordy = ($urandom_range(0, 9) < 6);
            step(iv, x, y, ordy);
            if (prev_hold) begin
                tests++; if (s_ov !== 1'b1 || s_z !== prev_z) begin fails++; $display("FAIL rnd_hold got ov=%b z=%h want 1/%h", s_ov, s_z, prev_z); end
            end
            if (s_ms) begin
                tests++;
                if (opq.size() == 0 || {s_mx, s_my} !== opq[0]) begin
                    fails++; $display("FAIL rnd_launch got %h/%h want %h", s_mx, s_my, (opq.size() != 0) ? opq[0] : '0);
                end
                if (opq.size() != 0) void'(opq.pop_front());
            end
            if (s_popped) begin
                tests++;
                if (exq.size() == 0 || s_z !== exq[0]) begin
                    fails++; $display("FAIL rnd_z%0d got %h want %h", recv, s_z, (exq.size() != 0) ? exq[0] : '0);
                end
                if (exq.size() != 0) void'(exq.pop_front());
                recv++;
            end
            if (s_pushed) begin
                exq.push_back(ref_mul(x, y));
                opq.push_back({x, y});
                sent++;
            end
            prev_hold = s_ov && !ordy;
            prev_z = s_z;
            s++;
        end
        tests++; if (recv != 40) begin fails++; $display("FAIL rnd_count got %0d want 40", recv); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_extremes();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
